// File: rtl/mppt_pno_multi.sv
// Multi-channel perturb-and-observe MPPT: one shared multiplier walks the channels, one shared PWM carrier.
// Optional build macro MPPT_DEADBAND_EN: power changes within +/-DEADBAND are treated as "no change".
//
// state | meaning
// IDLE  | waiting for a sample vector, sample_ready high
// MUL   | registering P = v*i for channel ch
// UPD   | P&O step of channel ch, then next channel or back to IDLE
module mppt_pno_multi #(
  parameter int NCH       = 2,
  parameter int DW        = 16,
  parameter int DUTY_W    = 8,
  parameter int DUTY_INIT = 128,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240,
  parameter int STEP      = 1,
  parameter int DEADBAND  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        en,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [NCH*DW-1:0]     v_in,
  input  logic [NCH*DW-1:0]     i_in,
  output logic [NCH*DUTY_W-1:0] duty_out,
  output logic [NCH-1:0]        pwm_out,
  output logic                  busy
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = 2 * DW;

  localparam logic [DUTY_W-1:0] DUTY_INIT_V = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W-1:0] DUTY_MIN_V  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] DUTY_MAX_V  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DUTY_STEP_V = DUTY_W'(STEP);
  localparam logic [DUTY_W:0]   D_STEP      = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0]   D_MAX       = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]   D_DN_LIM    = (DUTY_W+1)'(DUTY_MIN + STEP);

  if (NCH < 1 || NCH > 8 || DEADBAND < 0) begin : g_bad_param
    $error("mppt_pno_multi: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, MUL, UPD} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic              accept, last_ch;
  logic [DW-1:0]     v_lat [NCH];
  logic [DW-1:0]     i_lat [NCH];
  logic [PW-1:0]     prod;
  logic [PW-1:0]     pprev [NCH];
  logic [DUTY_W-1:0] duty [NCH];
  logic [DUTY_W-1:0] shadow [NCH];
  logic [NCH-1:0]    dir, primed, pwm_q;
  logic [DUTY_W-1:0] carrier;

  logic              p_gt, p_lt, step_up, upd_dir;
  logic [DUTY_W:0]   duty_ext;
  logic [DUTY_W-1:0] upd_duty;
`ifdef MPPT_DEADBAND_EN
  localparam logic [PW:0] DB_LIM = (PW+1)'(DEADBAND);
  logic [PW:0] p_diff, p_mag;
`endif

  assign last_ch      = (ch == CH_W'(NCH - 1));
  assign sample_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign pwm_out      = pwm_q;

  always_comb begin
    for (int c = 0; c < NCH; c++) duty_out[c*DUTY_W +: DUTY_W] = duty[c];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (sample_valid) begin
        accept    = 1'b1;
        state_nxt = MUL;
      end
      MUL:     state_nxt = UPD;
      UPD:     state_nxt = last_ch ? IDLE : MUL;
      default: state_nxt = IDLE;
    endcase
  end

  // Step decision for the channel currently selected by ch
  always_comb begin
    p_gt = (prod > pprev[ch]);
    p_lt = (prod < pprev[ch]);
`ifdef MPPT_DEADBAND_EN
    p_diff = {1'b0, prod} - {1'b0, pprev[ch]};
    p_mag  = p_diff[PW] ? (~p_diff + 1'b1) : p_diff;
    if (p_mag <= DB_LIM) begin
      p_gt = 1'b0;
      p_lt = 1'b0;
    end
`endif
    step_up  = p_lt ? ~dir[ch] : dir[ch];
    duty_ext = {1'b0, duty[ch]};
    upd_duty = duty[ch];
    upd_dir  = dir[ch];
    if (p_gt || p_lt) begin
      // A step that would cross a rail pins the duty and turns the search around
      if (step_up) begin
        if (duty_ext + D_STEP > D_MAX) begin
          upd_duty = DUTY_MAX_V;
          upd_dir  = 1'b0;
        end else begin
          upd_duty = DUTY_W'(duty_ext + D_STEP);
          upd_dir  = 1'b1;
        end
      end else begin
        if (duty_ext < D_DN_LIM) begin
          upd_duty = DUTY_MIN_V;
          upd_dir  = 1'b1;
        end else begin
          upd_duty = duty[ch] - DUTY_STEP_V;
          upd_dir  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      prod    <= '0;
      carrier <= '0;
      pwm_q   <= '0;
      dir     <= '1;
      primed  <= '0;
      for (int c = 0; c < NCH; c++) begin
        duty[c]   <= DUTY_INIT_V;
        shadow[c] <= DUTY_INIT_V;
        pprev[c]  <= '0;
        v_lat[c]  <= '0;
        i_lat[c]  <= '0;
      end
    end else begin
      if (accept) begin
        ch <= '0;
        for (int c = 0; c < NCH; c++) begin
          v_lat[c] <= v_in[c*DW +: DW];
          i_lat[c] <= i_in[c*DW +: DW];
        end
      end else if (state == UPD && !last_ch) begin
        ch <= ch + 1'b1;
      end

      if (state == MUL) prod <= PW'(v_lat[ch]) * PW'(i_lat[ch]);

      carrier <= carrier + 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (carrier == '1) shadow[c] <= duty[c];
        pwm_q[c] <= en[c] & (carrier < shadow[c]);

        if (!en[c]) begin
          duty[c]   <= DUTY_INIT_V;
          dir[c]    <= 1'b1;
          primed[c] <= 1'b0;
        end else if (state == UPD && ch == CH_W'(c)) begin
          pprev[c]  <= prod;
          primed[c] <= 1'b1;
          if (primed[c]) begin
            duty[c] <= upd_duty;
            dir[c]  <= upd_dir;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mppt_pno_multi.sv
// Bench for mppt_pno_multi: directed tables plus random vectors against a vector-level P&O model.
module tb_mppt_pno_multi;

  localparam int NCH = 2, DW = 16, DUTY_W = 8;
  localparam int INIT = 128, DMIN = 16, DMAX = 240, STEP = 1;
`ifdef MPPT_DEADBAND_EN
  localparam int DEADBAND = 1000;
`else
  localparam int DEADBAND = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] en = '1;
  logic sample_valid = 1'b0;
  logic sample_ready, busy;
  logic [NCH*DW-1:0] v_in = '0, i_in = '0;
  logic [NCH*DUTY_W-1:0] duty_out;
  logic [NCH-1:0] pwm_out;

  always #5 clk = ~clk;

  mppt_pno_multi #(.NCH(NCH), .DW(DW), .DUTY_W(DUTY_W), .DUTY_INIT(INIT), .DUTY_MIN(DMIN),
                   .DUTY_MAX(DMAX), .STEP(STEP), .DEADBAND(DEADBAND)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .v_in(v_in), .i_in(i_in), .duty_out(duty_out), .pwm_out(pwm_out), .busy(busy));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Vector-level model: one call processes a whole accepted vector
  int     m_duty [NCH];
  bit     m_dir [NCH];
  bit     m_primed [NCH];
  longint m_pprev [NCH];
  longint vv [NCH], ii [NCH];

  function automatic void m_disable(input int c);
    m_duty[c] = INIT; m_dir[c] = 1'b1; m_primed[c] = 1'b0;
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_disable(c);
      m_pprev[c] = 0;
    end
  endfunction

  function automatic void m_apply();
    longint p, d;
    bit same;
    for (int c = 0; c < NCH; c++) begin
      p = vv[c] * ii[c];
      if (!en[c]) m_disable(c);
      else if (!m_primed[c]) begin
        m_primed[c] = 1'b1;
        m_pprev[c] = p;
      end else begin
        d = p - m_pprev[c];
        same = (d == 0);
`ifdef MPPT_DEADBAND_EN
        same = ((d < 0) ? -d : d) <= DEADBAND;
`endif
        if (!same) begin
          if (d < 0) m_dir[c] = !m_dir[c];
          if (m_dir[c]) begin
            if (m_duty[c] + STEP > DMAX) begin m_duty[c] = DMAX; m_dir[c] = 1'b0; end
            else m_duty[c] = m_duty[c] + STEP;
          end else begin
            if (m_duty[c] - STEP < DMIN) begin m_duty[c] = DMIN; m_dir[c] = 1'b1; end
            else m_duty[c] = m_duty[c] - STEP;
          end
        end
        m_pprev[c] = p;
      end
    end
  endfunction

  function automatic int duty_of(input int c);
    return int'(duty_out[c*DUTY_W +: DUTY_W]);
  endfunction

  task automatic drive_vec();
    for (int c = 0; c < NCH; c++) begin
      v_in[c*DW +: DW] = DW'(vv[c]);
      i_in[c*DW +: DW] = DW'(ii[c]);
    end
  endtask

  task automatic set_en(input logic [NCH-1:0] e);
    @(negedge clk);
    en = e;
    for (int c = 0; c < NCH; c++) if (!e[c]) m_disable(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  // One handshake, junk on the inputs while busy, exact per-channel latency checks
  task automatic send_vec();
    int t, low;
    int old [NCH];
    t = 0;
    @(negedge clk);
    while (!sample_ready && t < 50) begin @(negedge clk); t++; end
    chk("ready_wait", sample_ready, 1);
    for (int c = 0; c < NCH; c++) old[c] = m_duty[c];
    drive_vec();
    sample_valid = 1'b1;
    m_apply();
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    v_in = (NCH*DW)'({$urandom, $urandom});
    i_in = (NCH*DW)'({$urandom, $urandom});
    low = 0;
    for (int k = 0; k <= 2*NCH; k++) begin
      @(negedge clk);
      if (k < 2*NCH && !sample_ready && busy) low++;
      if (k % 2 == 1) chk("duty_hold", duty_of((k-1)/2), old[(k-1)/2]);
      if (k >= 2 && k % 2 == 0) chk("duty_upd", duty_of((k-2)/2), m_duty[(k-2)/2]);
    end
    chk("busy_cycles", low, 2*NCH);
    chk("ready_after", sample_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  task automatic wait_rise(input int c, output bit ok);
    int t;
    t = 0;
    while (pwm_out[c] && t < 600) begin @(negedge clk); t++; end
    while (!pwm_out[c] && t < 600) begin @(negedge clk); t++; end
    ok = pwm_out[c];
  endtask

  task automatic count_run(input int c, output int w);
    w = 0;
    while (pwm_out[c] && w < 400) begin w++; @(negedge clk); end
  endtask

  task automatic count_highs(input int c, output int n);
    n = 0;
    repeat (256) begin @(negedge clk); if (pwm_out[c]) n++; end
  endtask

  typedef struct { int v0, i0, v1, i1, d0, d1; } vec_t;
  vec_t tbl [5];

  initial begin
    int n, w1, w2, acc, low, e1, e2, expd;
    bit ok;
    logic [NCH-1:0] e;

    tbl[0] = '{1500, 500, 100, 100, 128, 128};
    tbl[1] = '{1600, 550, 100, 200, 129, 129};
    tbl[2] = '{1400, 450, 100, 150, 128, 128};
    tbl[3] = '{1400, 450, 100, 100, 128, 129};
    tbl[4] = '{1000, 1000, 100, 100, 127, 129};

    do_reset();
    chk("rst_duty0", duty_of(0), INIT);
    chk("rst_duty1", duty_of(1), INIT);
    chk("rst_ready", sample_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pwm", pwm_out, 0);
    for (int c = 0; c < NCH; c++) begin
      count_highs(c, n);
      chk("pwm_init_width", n, INIT);
    end

    for (int r = 0; r < 5; r++) begin
      vv[0] = tbl[r].v0; ii[0] = tbl[r].i0;
      vv[1] = tbl[r].v1; ii[1] = tbl[r].i1;
      send_vec();
      chk("tbl_duty0", duty_of(0), tbl[r].d0);
      chk("tbl_duty1", duty_of(1), tbl[r].d1);
    end

    // Duty change in the middle of a PWM period takes effect from the next wrap
    repeat (300) @(negedge clk);
    wait_rise(0, ok);
    chk("pwm_rise_seen", ok, 1);
    e1 = m_duty[0];
    fork
      count_run(0, w1);
      begin
        repeat (20) @(negedge clk);
        vv[0] = 1000; ii[0] = 1001; vv[1] = 100; ii[1] = 100;
        send_vec();
      end
    join
    e2 = m_duty[0];
    chk("mid_step_duty", e2, 126);
    wait_rise(0, ok);
    count_run(0, w2);
    chk("pwm_old_width", w1, e1);
    chk("pwm_new_width", w2, e2);

    set_en(2'b01);
    @(negedge clk);
    chk("dis_duty1", duty_of(1), INIT);
    chk("dis_pwm1", pwm_out[1], 0);
    vv[1] = $urandom_range(0, 65535); ii[1] = $urandom_range(0, 65535);
    send_vec();
    chk("dis_vec_duty1", duty_of(1), INIT);
    set_en(2'b11);
    vv[1] = 200; ii[1] = 200;
    send_vec();
    chk("reen_prime_duty1", duty_of(1), INIT);
    ii[1] = 201;
    send_vec();
    chk("reen_step_duty1", duty_of(1), INIT + 1);
    chk("reen_duty0", duty_of(0), 126);

    // Sample_valid held high: one accept per IDLE visit
    @(negedge clk);
    vv[0] = 1234; ii[0] = 567; vv[1] = 890; ii[1] = 12;
    drive_vec();
    sample_valid = 1'b1;
    acc = 0; low = 0;
    for (int k = 0; k < 10; k++) begin
      if (sample_ready) begin acc++; m_apply(); end
      else low++;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("hold_accepts", acc, 2);
    chk("hold_ready_low", low, 8);
    for (int c = 0; c < NCH; c++) chk("hold_duty", duty_of(c), m_duty[c]);

    // Upper clamp
    do_reset();
    vv[0] = 1000; ii[0] = 1000; vv[1] = 1000; ii[1] = 1000;
    send_vec();
    for (int k = 1; k <= 114; k++) begin
      ii[0] = 1000 + k; ii[1] = 1000 + k;
      send_vec();
      if (k >= 111) begin
        expd = (k == 111) ? 239 : (k == 114) ? 239 : 240;
        chk("clamp_duty0", duty_of(0), expd);
        chk("clamp_duty1", duty_of(1), expd);
      end
    end

    // Reset during UPD of channel 0
    @(negedge clk);
    ii[0] = 2000; ii[1] = 2000;
    drive_vec();
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_duty0", duty_of(0), INIT);
    chk("midrst_duty1", duty_of(1), INIT);
    chk("midrst_ready", sample_ready, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    m_reset();

    for (int r = 0; r < 300; r++) begin
      for (int c = 0; c < NCH; c++) e[c] = ($urandom_range(0, 5) != 0);
      set_en(e);
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, 7);
        if (n < 2) begin vv[c] = $urandom_range(0, 3); ii[c] = $urandom_range(0, 3); end
        else if (n > 2) begin vv[c] = $urandom_range(0, 65535); ii[c] = $urandom_range(0, 65535); end
      end
      send_vec();
    end

    repeat (300) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      count_highs(c, n);
      chk("pwm_rand_width", n, en[c] ? m_duty[c] : 0);
    end

    do_reset();
    set_en('1);
    vv[0] = 100; ii[0] = 10000; vv[1] = 100; ii[1] = 10000;
    send_vec();
    ii[0] = 10008; ii[1] = 10008;
    send_vec();
`ifdef MPPT_DEADBAND_EN
    chk("db_small_change", duty_of(0), 128);
`else
    chk("db_small_change", duty_of(0), 129);
`endif
    ii[0] = 10020; ii[1] = 10020;
    send_vec();
`ifdef MPPT_DEADBAND_EN
    chk("db_large_change", duty_of(0), 129);
`else
    chk("db_large_change", duty_of(0), 130);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
